imm_packer: RTL and testbench
=============================

// Module: imm_packer
// PURPOSE
// - Inverse of the immediate extender: takes a 32-bit constant and emits the
//   16-bit immediate field(s) plus extender opcode (EOp) that rebuild it.
// - Sits in the instruction-generation path (assembler / pseudo-op expander)
//   ahead of instruction memory.
// - Unencodable values expand to a two-beat lui+ori pair (EOp 2, then EOp 1).
// PARAMETERS
// - CNT_W  16  width of the saturating split-pair counter
// PORTS
// - clk        in   1   clock; all state on rising edge
// - rst_n      in   1   async active-low reset
// - in_valid   in   1   in_value presented
// - in_ready   out  1   packer accepts in_value this cycle
// - in_value   in   32  constant to encode
// - out_valid  out  1   out_imm/out_eop/out_last valid
// - out_ready  in   1   consumer accepts the current beat
// - out_imm    out  16  immediate field
// - out_eop    out  2   EOp: 0 sext, 1 zext, 2 upper (imm<<16), 3 sext<<2
// - out_last   out  1   final beat of this value
// - split_cnt  out  CNT_W  number of values expanded to two beats (saturating)
// BEHAVIOUR
// - Reset: one clock, async active-low; rst_n low forces state IDLE,
//   out_valid=0, out_imm=0, out_eop=0, out_last=0, split_cnt=0 immediately,
//   any beat in flight is dropped.
// - Handshake: fire = valid&&ready. out_* hold stable while out_valid&&!out_ready.
// - in_ready = (state==IDLE) || (out_fire && out_last); combinational from
//   out_ready. Gives one value per cycle for single-beat encodings.
// - Encoding priority (first match wins) on v = in_value:
//   1. v[31:15] all equal          -> imm=v[15:0],  EOp 0, single beat
//   2. v[31:16]==0                 -> imm=v[15:0],  EOp 1, single beat
//   3. v[15:0]==0                  -> imm=v[31:16], EOp 2, single beat
//   4. (macro only) v[1:0]==0 && v[31:17] all equal -> imm=v[17:2], EOp 3
//   5. otherwise split: beat A imm=v[31:16] EOp 2 last=0;
//                       beat B imm=v[15:0]  EOp 1 last=1
//   Note: v=0 matches rule 1 (EOp 0, imm 0).
// - FSM (registered outputs, latency 1 cycle from in-fire to out_valid):
//   IDLE : in_fire -> SINGLE (rules 1-4) or HI (rule 5); load outputs.
//   SINGLE: out_fire -> IDLE, or SINGLE/HI if in_fire same cycle.
//   HI   : out_fire -> LO; load beat B (low half held in a 16-bit register).
//   LO   : out_fire -> IDLE, or SINGLE/HI if in_fire same cycle.
//   out_valid=1 in SINGLE, HI, LO; 0 in IDLE.
// - split_cnt increments on entry to HI; saturates at all-ones, no wrap.
// - Simultaneous out_fire(last) and in_fire: next value loaded in same edge,
//   no bubble. in_valid while busy and not finishing: stalled (in_ready=0).
// CONFIGURATION
// - IMM_PACKER_SHIFT_EN defined: rule 4 active; EOp 3 emitted for word-aligned
//   offsets in +/-128 KiB not caught by rules 1-3.
// - Undefined: rule 4 skipped; such values fall to rule 5; EOp 3 never emitted.
// TESTING
// - in 0xFFFF_8000 -> one beat imm 0x8000 EOp 0 last 1; split_cnt 0
// - in 0x0000_ABCD -> one beat imm 0xABCD EOp 1 last 1
// - in 0x1234_5678, out_ready held 0 for 3 cycles -> beat A 0x1234/EOp2/last0
//   stable, then 0x5678/EOp1/last1; split_cnt 1; in_ready 0 until beat B fires
// - in 0x0001_FFFC -> with SHIFT_EN imm 0x7FFF EOp 3; without, two beats
//   0x0001/EOp2 then 0xFFFC/EOp1
// - back-to-back 0x5, 0x7FFF_0000, 0x1 with out_ready=1 -> one beat per cycle,
//   in_ready stays 1; rst_n pulsed low mid-HI -> out_valid 0 at once, split_cnt 0

Source files
------------

// File: rtl/imm_packer.sv
// Immediate packer: turns a 32-bit constant into one or two (imm, EOp) beats for the extender.
// Optional macro IMM_PACKER_SHIFT_EN enables the word-aligned sext<<2 encoding (EOp 3).
module imm_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic [1:0]       out_eop,
  output logic             out_last,
  output logic [CNT_W-1:0] split_cnt
);

  localparam logic [1:0] EOP_SEXT  = 2'd0;
  localparam logic [1:0] EOP_ZEXT  = 2'd1;
  localparam logic [1:0] EOP_UPPER = 2'd2;
`ifdef IMM_PACKER_SHIFT_EN
  localparam logic [1:0] EOP_SHIFT = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, SINGLE, HI, LO} state_e;

  typedef struct packed {
    logic        split;
    logic [15:0] imm;
    logic [1:0]  eop;
  } enc_t;

  // First matching rule wins; a split carries the upper half in imm.
  function automatic enc_t encode(input logic [31:0] v);
    enc_t e;
    e.split = 1'b0;
    e.imm   = v[15:0];
    e.eop   = EOP_SEXT;
    if ((&v[31:15]) || (~|v[31:15])) begin
      e.eop = EOP_SEXT;
    end else if (~|v[31:16]) begin
      e.eop = EOP_ZEXT;
    end else if (~|v[15:0]) begin
      e.imm = v[31:16];
      e.eop = EOP_UPPER;
    end
`ifdef IMM_PACKER_SHIFT_EN
    else if ((~|v[1:0]) && ((&v[31:17]) || (~|v[31:17]))) begin
      e.imm = v[17:2];
      e.eop = EOP_SHIFT;
    end
`endif
    else begin
      e.split = 1'b1;
      e.imm   = v[31:16];
      e.eop   = EOP_UPPER;
    end
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       imm_q, imm_d;
  logic [1:0]        eop_q, eop_d;
  logic              last_q, last_d;
  logic [15:0]       lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_fire;
  logic              in_fire;
  enc_t              enc;

  always_comb begin
    enc       = encode(in_value);
    out_valid = (state_q != IDLE);
    out_fire  = out_valid && out_ready;
    in_ready  = (state_q == IDLE) || (out_fire && last_q);
    in_fire   = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    eop_d   = eop_q;
    last_d  = last_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    // A new value takes priority: it can only fire when the current beat is the last one.
    if (in_fire) begin
      imm_d = enc.imm;
      eop_d = enc.eop;
      lo_d  = in_value[15:0];
      if (enc.split) begin
        state_d = HI;
        last_d  = 1'b0;
        cnt_d   = sat_inc(cnt_q);
      end else begin
        state_d = SINGLE;
        last_d  = 1'b1;
      end
    end else if (out_fire) begin
      if (state_q == HI) begin
        state_d = LO;
        imm_d   = lo_q;
        eop_d   = EOP_ZEXT;
        last_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      imm_q   <= '0;
      eop_q   <= '0;
      last_q  <= 1'b0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_imm   = imm_q;
  assign out_eop   = eop_q;
  assign out_last  = last_q;
  assign split_cnt = cnt_q;

endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer: vector table plus stall, back-to-back and reset sequences.
module tb_imm_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;
  logic [15:0] split_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  imm_packer #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_eop   (out_eop),
    .out_last  (out_last),
    .split_cnt (split_cnt)
  );

  typedef struct {
    logic [31:0] v;
    int          beats;
    logic [15:0] imm0;
    logic [1:0]  eop0;
    logic [15:0] imm1;
    logic [1:0]  eop1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic [15:0] imm, input logic [1:0] eop,
                          input logic last);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_imm"},   32'(out_imm),   32'(imm));
    chk({name, "_eop"},   32'(out_eop),   32'(eop));
    chk({name, "_last"},  32'(out_last),  32'(last));
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    @(negedge clk);
    in_valid  = 1'b1;
    in_value  = t.v;
    out_ready = 1'b1;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (t.beats == 2) exp_cnt++;
    chk_beat($sformatf("v%0d_beat0", idx), t.imm0, t.eop0, t.beats == 1);
    chk($sformatf("v%0d_split_cnt", idx), 32'(split_cnt), 32'(exp_cnt));
    if (t.beats == 2) begin
      @(negedge clk);
      chk_beat($sformatf("v%0d_beat1", idx), t.imm1, t.eop1, 1'b1);
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;

    tbl[0]  = '{32'hFFFF_8000, 1, 16'h8000, 2'd0, 16'h0000, 2'd0};
    tbl[1]  = '{32'h0000_ABCD, 1, 16'hABCD, 2'd1, 16'h0000, 2'd0};
    tbl[2]  = '{32'h0000_0000, 1, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[3]  = '{32'h7FFF_0000, 1, 16'h7FFF, 2'd2, 16'h0000, 2'd0};
    tbl[4]  = '{32'h0000_7FFF, 1, 16'h7FFF, 2'd0, 16'h0000, 2'd0};
    tbl[5]  = '{32'h0000_8000, 1, 16'h8000, 2'd1, 16'h0000, 2'd0};
    tbl[6]  = '{32'h1234_5678, 2, 16'h1234, 2'd2, 16'h5678, 2'd1};
`ifdef IMM_PACKER_SHIFT_EN
    tbl[7]  = '{32'h0001_FFFC, 1, 16'h7FFF, 2'd3, 16'h0000, 2'd0};
    tbl[9]  = '{32'hFFFE_0004, 1, 16'h8001, 2'd3, 16'h0000, 2'd0};
`else
    tbl[7]  = '{32'h0001_FFFC, 2, 16'h0001, 2'd2, 16'hFFFC, 2'd1};
    tbl[9]  = '{32'hFFFE_0004, 2, 16'hFFFE, 2'd2, 16'h0004, 2'd1};
`endif
    tbl[8]  = '{32'hFFFF_0000, 1, 16'hFFFF, 2'd2, 16'h0000, 2'd0};
    tbl[10] = '{32'h8000_0001, 2, 16'h8000, 2'd2, 16'h0001, 2'd1};
    tbl[11] = '{32'hFFFF_FFFF, 1, 16'hFFFF, 2'd0, 16'h0000, 2'd0};

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm",   32'(out_imm),   32'd0);
    chk("rst_out_eop",   32'(out_eop),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_split_cnt", 32'(split_cnt), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Split value with consumer stalled; a second value waits behind it.
    @(negedge clk);
    in_valid  = 1'b1;
    in_value  = 32'h1234_5678;
    out_ready = 1'b0;
    @(negedge clk);
    in_value = 32'h0000_0005;
    exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("stall%0d_beatA", i), 16'h1234, 2'd2, 1'b0);
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("stall_in_ready_beatA_fire", 32'(in_ready), 32'd0);
    chk("stall_split_cnt", 32'(split_cnt), 32'(exp_cnt));
    @(negedge clk);
    chk_beat("stall_beatB", 16'h5678, 2'd1, 1'b1);
    chk("stall_in_ready_beatB", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("stall_next", 16'h0005, 2'd0, 1'b1);
    @(negedge clk);
    chk("stall_idle", 32'(out_valid), 32'd0);

    // Back-to-back single-beat values, one per cycle.
    @(negedge clk);
    in_valid  = 1'b1;
    in_value  = 32'h0000_0005;
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("b2b0", 16'h0005, 2'd0, 1'b1);
    chk("b2b0_in_ready", 32'(in_ready), 32'd1);
    in_value = 32'h7FFF_0000;
    @(negedge clk);
    chk_beat("b2b1", 16'h7FFF, 2'd2, 1'b1);
    chk("b2b1_in_ready", 32'(in_ready), 32'd1);
    in_value = 32'h0000_0001;
    @(negedge clk);
    chk_beat("b2b2", 16'h0001, 2'd0, 1'b1);
    chk("b2b2_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset while beat A is held.
    @(negedge clk);
    in_valid  = 1'b1;
    in_value  = 32'h8000_0001;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt++;
    chk_beat("hi_before_rst", 16'h8000, 2'd2, 1'b0);
    chk("hi_split_cnt", 32'(split_cnt), 32'(exp_cnt));
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_split_cnt", 32'(split_cnt), 32'(exp_cnt));
    chk("midrst_out_imm",   32'(out_imm),   32'd0);
    chk("midrst_out_eop",   32'(out_eop),   32'd0);
    chk("midrst_out_last",  32'(out_last),  32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    chk("postrst_in_ready",  32'(in_ready),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
